// File: rtl/seq_datapath_pkg.sv
// Shared definitions for the sequenced bus datapath: opcodes, sequencer states, ALU.
package seq_datapath_pkg;

  // Widest datapath the shared ALU function supports.
  localparam int ALU_MAX_W = 64;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_MOVE = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LDY  = 3'd1,
    ST_EXE  = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  // Opcodes 11x are reserved and never accepted.
  function automatic logic op_is_valid(input logic [2:0] op);
    return (op <= OP_MOVE);
  endfunction

  // AND/OR/ADD/SUB share the 00x/01x encodings.
  function automatic logic op_is_alu(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // ALU on the widest supported width; callers truncate, which keeps ADD/SUB wrapping.
  function automatic logic [ALU_MAX_W-1:0] alu_eval(input logic [2:0] op,
                                                    input logic [ALU_MAX_W-1:0] a,
                                                    input logic [ALU_MAX_W-1:0] b);
    logic [ALU_MAX_W-1:0] res;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      default: res = {ALU_MAX_W{1'b0}};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seq_datapath_dp_reg.sv
// Generic datapath register: asynchronous active-low clear, synchronous load enable.
module dp_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold the value until load, clear asynchronously.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q <= {WIDTH{1'b0}};
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/seq_datapath.sv
// Single-bus datapath (register file, Y, Z, MDR, pc, ALU) driven by its own micro-op sequencer.
module seq_datapath
  import seq_datapath_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NREGS  = 16,
  localparam int RSEL_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [RSEL_W-1:0] ra,
  input  logic [RSEL_W-1:0] rb,
  input  logic [RSEL_W-1:0] rc,
  output logic              mem_req,
  input  logic              mem_valid,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              zero,
  output logic [WIDTH-1:0]  pc,
  output logic [WIDTH-1:0]  bus_out,
  input  logic [RSEL_W-1:0] dbg_sel,
  output logic [WIDTH-1:0]  dbg_data
);

  state_t              state_r, state_s;
  logic [2:0]          op_r;
  logic [RSEL_W-1:0]   ra_r, rb_r, rc_r;
  logic                accept_s;
  logic                done_r, zero_r;
  logic [WIDTH-1:0]    bus_s;
  logic [WIDTH-1:0]    alu_s;
  logic [WIDTH-1:0]    y_q, z_q, mdr_q, pc_q;
  logic [WIDTH-1:0]    reg_q [NREGS];
  logic [NREGS-1:0]    reg_load_s;

  assign accept_s = (state_r == ST_IDLE) && start && op_is_valid(op);

  // Sequencer state register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; reserved opcodes leave the sequencer idle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (op_is_alu(op)) begin
            state_s = ST_LDY;
          end else if (op == OP_LOAD) begin
            state_s = ST_MEM;
          end else begin
            state_s = ST_WB;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LDY:  state_s = ST_EXE;
      ST_EXE:  state_s = ST_WB;
      ST_MEM: begin
        if (mem_valid) begin
          state_s = ST_WB;
        end else begin
          state_s = ST_MEM;
        end
      end
      ST_WB:   state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Command fields are captured once on accept and held for the whole sequence.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      op_r <= 3'b000;
      ra_r <= {RSEL_W{1'b0}};
      rb_r <= {RSEL_W{1'b0}};
      rc_r <= {RSEL_W{1'b0}};
    end else if (accept_s) begin
      op_r <= op;
      ra_r <= ra;
      rb_r <= rb;
      rc_r <= rc;
    end else begin
      op_r <= op_r;
      ra_r <= ra_r;
      rb_r <= rb_r;
      rc_r <= rc_r;
    end
  end

  // Shared bus: exactly one source per state, zero when nothing drives it.
  always_comb begin
    bus_s = {WIDTH{1'b0}};
    case (state_r)
      ST_LDY: bus_s = reg_q[rb_r];
      ST_EXE: bus_s = reg_q[rc_r];
      ST_WB: begin
        case (op_r)
          OP_LOAD: bus_s = mdr_q;
          OP_MOVE: bus_s = reg_q[rb_r];
          default: bus_s = z_q;
        endcase
      end
      default: bus_s = {WIDTH{1'b0}};
    endcase
  end

  assign alu_s = WIDTH'(alu_eval(op_r, ALU_MAX_W'(y_q), ALU_MAX_W'(bus_s)));

  // Status flags: done pulses the cycle after writeback, zero tracks the last written value.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      done_r <= 1'b0;
      zero_r <= 1'b0;
    end else if (state_r == ST_WB) begin
      done_r <= 1'b1;
      zero_r <= (bus_s == {WIDTH{1'b0}});
    end else begin
      done_r <= 1'b0;
      zero_r <= zero_r;
    end
  end

  dp_reg #(.WIDTH(WIDTH)) u_y   (.clk(clk), .clr(clr), .load(state_r == ST_LDY),
                                 .d(bus_s), .q(y_q));
  dp_reg #(.WIDTH(WIDTH)) u_z   (.clk(clk), .clr(clr), .load(state_r == ST_EXE),
                                 .d(alu_s), .q(z_q));
  dp_reg #(.WIDTH(WIDTH)) u_mdr (.clk(clk), .clr(clr), .load((state_r == ST_MEM) && mem_valid),
                                 .d(mem_rdata), .q(mdr_q));
  dp_reg #(.WIDTH(WIDTH)) u_pc  (.clk(clk), .clr(clr), .load(accept_s),
                                 .d(pc_q + {{(WIDTH-1){1'b0}}, 1'b1}), .q(pc_q));

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
    assign reg_load_s[gi] = (state_r == ST_WB) && (ra_r == RSEL_W'(gi));
    dp_reg #(.WIDTH(WIDTH)) u_r (.clk(clk), .clr(clr), .load(reg_load_s[gi]),
                                 .d(bus_s), .q(reg_q[gi]));
  end

  assign mem_req  = (state_r == ST_MEM);
  assign busy     = (state_r != ST_IDLE);
  assign done     = done_r;
  assign zero     = zero_r;
  assign pc       = pc_q;
  assign bus_out  = bus_s;
  assign dbg_data = reg_q[dbg_sel];

endmodule

// File: tb/tb_seq_datapath.sv
// Bench for seq_datapath: transaction-level model compared every cycle, plus directed literals.
module tb_seq_datapath;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit / 16-register instance
  logic        clr = 1'b1, start = 1'b0, mem_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [3:0]  ra = 4'd0, rb = 4'd0, rc = 4'd0, dbg_sel = 4'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_req, busy, done, zero;
  logic [31:0] pc, bus_out, dbg_data;

  // 8-bit / 4-register instance
  logic        clr8 = 1'b1, start8 = 1'b0, mem_valid8 = 1'b1;
  logic [2:0]  op8 = 3'd0;
  logic [1:0]  ra8 = 2'd0, rb8 = 2'd0, rc8 = 2'd0, dbg_sel8 = 2'd0;
  logic [7:0]  mem_rdata8 = 8'd0;
  logic        mem_req8, busy8, done8, zero8;
  logic [7:0]  pc8, bus_out8, dbg_data8;

  seq_datapath #(.WIDTH(32), .NREGS(16)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .mem_req(mem_req), .mem_valid(mem_valid), .mem_rdata(mem_rdata), .busy(busy),
    .done(done), .zero(zero), .pc(pc), .bus_out(bus_out), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data));

  seq_datapath #(.WIDTH(8), .NREGS(4)) dut8 (
    .clk(clk), .clr(clr8), .start(start8), .op(op8), .ra(ra8), .rb(rb8), .rc(rc8),
    .mem_req(mem_req8), .mem_valid(mem_valid8), .mem_rdata(mem_rdata8), .busy(busy8),
    .done(done8), .zero(zero8), .pc(pc8), .bus_out(bus_out8), .dbg_sel(dbg_sel8),
    .dbg_data(dbg_data8));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: result is computed on accept, writeback happens a fixed number of
  // cycles later (ALU 3, MOVE 1) or one cycle after memory data arrives (LOAD).
  logic [31:0] m_regs [16];
  logic [31:0] m_pc, m_res;
  logic [3:0]  m_ra;
  logic        m_busy, m_done, m_zero, m_memwait;
  int          m_wb_in;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 16; i++) m_regs[i] <= 32'd0;
      m_pc <= 32'd0; m_busy <= 1'b0; m_done <= 1'b0; m_zero <= 1'b0;
      m_memwait <= 1'b0; m_wb_in <= 0; m_res <= 32'd0; m_ra <= 4'd0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start && op <= 3'd5) begin
          m_pc <= m_pc + 32'd1;
          m_ra <= ra;
          m_busy <= 1'b1;
          case (op)
            3'd0: m_res <= m_regs[rb] & m_regs[rc];
            3'd1: m_res <= m_regs[rb] | m_regs[rc];
            3'd2: m_res <= m_regs[rb] + m_regs[rc];
            3'd3: m_res <= m_regs[rb] - m_regs[rc];
            3'd5: m_res <= m_regs[rb];
            default: m_res <= 32'd0;
          endcase
          m_memwait <= (op == 3'd4);
          m_wb_in   <= (op == 3'd4) ? 0 : ((op == 3'd5) ? 1 : 3);
        end
      end else if (m_memwait) begin
        if (mem_valid) begin
          m_res <= mem_rdata; m_memwait <= 1'b0; m_wb_in <= 1;
        end
      end else if (m_wb_in == 1) begin
        m_regs[m_ra] <= m_res;
        m_zero <= (m_res == 32'd0);
        m_done <= 1'b1;
        m_busy <= 1'b0;
        m_wb_in <= 0;
      end else begin
        m_wb_in <= m_wb_in - 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_busy & m_memwait});
    chk("zero", {31'd0, zero}, {31'd0, m_zero});
    chk("pc", pc, m_pc);
    chk("dbg_data", dbg_data, m_regs[dbg_sel]);
    if (!m_busy) chk("idle_bus", bus_out, 32'd0);
  end

  int lat, nreq;

  // Issue one command starting now; count cycles until done, drive mem_valid after waitc MEM cycles.
  task automatic run_cmd(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [31:0] rd, input int waitc,
                         output int l, output int nr);
    start = 1'b1; op = o; ra = a; rb = b; rc = c; mem_rdata = rd; mem_valid = 1'b0;
    l = 0; nr = 0;
    do begin
      @(negedge clk); #1;
      start = 1'b0;
      l++;
      if (mem_req) begin
        nr++;
        mem_valid = (nr > waitc);
      end else begin
        mem_valid = 1'b0;
      end
    end while (!done && l < 60);
    chk("done_within_bound", {31'd0, done}, 32'd1);
  endtask

  task automatic dbg_chk(input string name, input logic [3:0] idx, input logic [31:0] exp);
    @(negedge clk); #1;
    dbg_sel = idx;
    #1;
    chk(name, dbg_data, exp);
  endtask

  task automatic run8(input logic [2:0] o, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] c, input logic [7:0] rd);
    int l8;
    start8 = 1'b1; op8 = o; ra8 = a; rb8 = b; rc8 = c; mem_rdata8 = rd;
    l8 = 0;
    do begin
      @(negedge clk); #1;
      start8 = 1'b0;
      l8++;
    end while (!done8 && l8 < 20);
    chk("done8_within_bound", {31'd0, done8}, 32'd1);
  endtask

  initial begin
    #1 clr = 1'b0; clr8 = 1'b0;
    @(negedge clk);
    chk("reset_pc", pc, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); #1 clr = 1'b1; clr8 = 1'b1;

    // Populate state, then clear mid-cycle.
    run_cmd(3'd4, 4'd4, 4'd0, 4'd0, 32'h99, 0, lat, nreq);
    run_cmd(3'd5, 4'd1, 4'd4, 4'd0, 32'd0, 0, lat, nreq);
    chk("pre_clr_pc", pc, 32'd2);
    @(posedge clk); #2 clr = 1'b0;
    #1;
    chk("clr_pc", pc, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 16; i++) dbg_chk("clr_dbg", 4'(i), 32'd0);
    @(negedge clk); #1 clr = 1'b1;

    // LOAD with three wait cycles.
    run_cmd(3'd4, 4'd2, 4'd0, 4'd0, 32'h34, 3, lat, nreq);
    chk("load_latency", 32'(lat), 32'd6);
    chk("load_mem_req_cycles", 32'(nreq), 32'd4);
    chk("load_pc", pc, 32'd1);
    dbg_chk("load_r2", 4'd2, 32'h34);

    // LOAD then AND.
    run_cmd(3'd4, 4'd3, 4'd0, 4'd0, 32'h45, 0, lat, nreq);
    chk("load0_latency", 32'(lat), 32'd3);
    run_cmd(3'd0, 4'd5, 4'd2, 4'd3, 32'd0, 0, lat, nreq);
    chk("and_latency", 32'(lat), 32'd4);
    chk("and_zero", {31'd0, zero}, 32'd0);
    dbg_chk("and_r5", 4'd5, 32'h4);

    // SUB wrap, SUB to zero, MOVE, then dest==source.
    run_cmd(3'd3, 4'd6, 4'd2, 4'd3, 32'd0, 0, lat, nreq);
    chk("sub_zero", {31'd0, zero}, 32'd0);
    dbg_chk("sub_r6", 4'd6, 32'hFFFF_FFEF);
    run_cmd(3'd3, 4'd7, 4'd2, 4'd2, 32'd0, 0, lat, nreq);
    chk("sub_self_zero", {31'd0, zero}, 32'd1);
    dbg_chk("sub_r7", 4'd7, 32'd0);
    run_cmd(3'd5, 4'd8, 4'd2, 4'd0, 32'd0, 0, lat, nreq);
    chk("move_latency", 32'(lat), 32'd2);
    dbg_chk("move_r8", 4'd8, 32'h34);
    run_cmd(3'd2, 4'd2, 4'd2, 4'd2, 32'd0, 0, lat, nreq);
    dbg_chk("add_self_r2", 4'd2, 32'h68);
    // Back-to-back: next start issued during the done cycle.
    run_cmd(3'd1, 4'd9, 4'd4, 4'd5, 32'd0, 0, lat, nreq);
    run_cmd(3'd5, 4'd13, 4'd9, 4'd0, 32'd0, 0, lat, nreq);
    chk("b2b_latency", 32'(lat), 32'd2);
    dbg_chk("or_r9", 4'd9, 32'h4);
    dbg_chk("b2b_r13", 4'd13, 32'h4);

    // Reserved opcode: no acceptance.
    start = 1'b1; op = 3'd6; ra = 4'd14;
    @(negedge clk); #1 start = 1'b0;
    chk("reserved_busy", {31'd0, busy}, 32'd0);
    chk("reserved_pc", pc, 32'd9);

    // Start pulsed during EXE is ignored.
    start = 1'b1; op = 3'd2; ra = 4'd10; rb = 4'd2; rc = 4'd8;
    @(negedge clk); #1 start = 1'b0;
    @(negedge clk); #1 start = 1'b1; op = 3'd5; ra = 4'd11; rb = 4'd2;
    @(negedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("exe_start_done", {31'd0, done}, 32'd1);
    chk("exe_start_pc", pc, 32'd10);
    dbg_chk("exe_start_r10", 4'd10, 32'h9C);
    dbg_chk("exe_start_r11", 4'd11, 32'd0);

    // Clear while waiting in MEM, then a normal LOAD.
    start = 1'b1; op = 3'd4; ra = 4'd12; mem_valid = 1'b0;
    @(negedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("mem_wait_req", {31'd0, mem_req}, 32'd1);
    #2 clr = 1'b0;
    #1;
    chk("mem_clr_busy", {31'd0, busy}, 32'd0);
    chk("mem_clr_req", {31'd0, mem_req}, 32'd0);
    chk("mem_clr_pc", pc, 32'd0);
    dbg_chk("mem_clr_r2", 4'd2, 32'd0);
    dbg_chk("mem_clr_r10", 4'd10, 32'd0);
    @(negedge clk); #1 clr = 1'b1;
    run_cmd(3'd4, 4'd12, 4'd0, 4'd0, 32'h77, 1, lat, nreq);
    chk("reload_latency", 32'(lat), 32'd4);
    chk("reload_pc", pc, 32'd1);
    dbg_chk("reload_r12", 4'd12, 32'h77);

    // Narrow instance: ADD wrap and pc wrap.
    run8(3'd4, 2'd1, 2'd0, 2'd0, 8'hF0);
    run8(3'd4, 2'd2, 2'd0, 2'd0, 8'h20);
    run8(3'd2, 2'd3, 2'd1, 2'd2, 8'h00);
    chk("w8_zero", {31'd0, zero8}, 32'd0);
    @(negedge clk); #1 dbg_sel8 = 2'd3; #1;
    chk("w8_add_wrap_r3", {24'd0, dbg_data8}, 32'h10);
    chk("w8_pc", {24'd0, pc8}, 32'd3);
    @(negedge clk); #1 clr8 = 1'b0;
    @(negedge clk); #1 clr8 = 1'b1;
    for (int i = 0; i < 255; i++) run8(3'd5, 2'd0, 2'd0, 2'd0, 8'h00);
    chk("w8_pc_255", {24'd0, pc8}, 32'hFF);
    run8(3'd5, 2'd0, 2'd0, 2'd0, 8'h00);
    chk("w8_pc_wrap", {24'd0, pc8}, 32'h00);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
